alu_issue_stage: RTL

- Execute-issue stage directly upstream of the 12-bit one-hot ALU.
- Decodes a MIPS32 integer instruction into the ALU's one-hot op vector and selects and extends the A/B operands.
- Registers the result toward the ALU through a 2-entry ready/valid skid buffer, so the decode path and the ALU path are cut by a register.
- Lets the ALU path run multi-cycle or stall without combinational backpressure reaching fetch/decode.

---
 rtl/alu_issue_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// MIPS32 integer decode and operand select ahead of the one-hot ALU, with a 2-entry skid buffer.
// Optional operand forwarding is enabled with `define ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A,
  output logic [DATA_WIDTH-1:0] out_B,
  output logic [OP_WIDTH-1:0]   out_ALUop,
  output logic [4:0]            out_dest,
  output logic                  out_wen,
  output logic                  out_ov_chk,
  output logic                  out_illegal
`ifdef ALU_ISSUE_FWD_EN
  ,
  input  logic                  fwd_valid,
  input  logic [4:0]            fwd_reg,
  input  logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_NOR  = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_SLT  = 6;
  localparam int unsigned OP_SLTU = 7;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 9;
  localparam int unsigned OP_SRA  = 10;
  localparam int unsigned OP_LUI  = 11;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [OP_WIDTH-1:0]   op;
    logic [4:0]            dest;
    logic                  wen;
    logic                  ov_chk;
    logic                  illegal;
  } entry_t;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = in_inst[31:26];
  assign rs     = in_inst[25:21];
  assign rt     = in_inst[20:16];
  assign rd     = in_inst[15:11];
  assign shamt  = in_inst[10:6];
  assign funct  = in_inst[5:0];
  assign imm    = in_inst[15:0];

  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;

`ifdef ALU_ISSUE_FWD_EN
  // Bypass a result not yet written to the GPR file; r0 is never forwarded.
  assign rs_val = (fwd_valid && (fwd_reg != 5'd0) && (fwd_reg == rs)) ? fwd_data : in_rs_data;
  assign rt_val = (fwd_valid && (fwd_reg != 5'd0) && (fwd_reg == rt)) ? fwd_data : in_rt_data;
`else
  assign rs_val = in_rs_data;
  assign rt_val = in_rt_data;
`endif

  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;

  assign imm_sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zext = DATA_WIDTH'(imm);

  entry_t                dec;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [OP_WIDTH-1:0]   op_sel;
  logic [4:0]            dest_sel;
  logic                  ov_sel;
  logic                  legal;

  // Instruction decode and operand selection.
  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    op_sel   = '0;
    dest_sel = 5'd0;
    ov_sel   = 1'b0;
    legal    = 1'b1;
    dec      = '0;
    if (opcode == 6'h00) begin
      dest_sel = rd;
      a_sel    = rs_val;
      b_sel    = rt_val;
      case (funct)
        6'h20: begin op_sel[OP_ADD] = 1'b1; ov_sel = 1'b1; end
        6'h21: op_sel[OP_ADD] = 1'b1;
        6'h22: begin op_sel[OP_SUB] = 1'b1; ov_sel = 1'b1; end
        6'h23: op_sel[OP_SUB] = 1'b1;
        6'h24: op_sel[OP_AND] = 1'b1;
        6'h25: op_sel[OP_OR] = 1'b1;
        6'h26: op_sel[OP_XOR] = 1'b1;
        6'h27: op_sel[OP_NOR] = 1'b1;
        6'h2A: op_sel[OP_SLT] = 1'b1;
        6'h2B: op_sel[OP_SLTU] = 1'b1;
        6'h00: begin op_sel[OP_SLL] = 1'b1; a_sel = DATA_WIDTH'(shamt); end
        6'h02: begin op_sel[OP_SRL] = 1'b1; a_sel = DATA_WIDTH'(shamt); end
        6'h03: begin op_sel[OP_SRA] = 1'b1; a_sel = DATA_WIDTH'(shamt); end
        6'h04: op_sel[OP_SLL] = 1'b1;
        6'h06: op_sel[OP_SRL] = 1'b1;
        6'h07: op_sel[OP_SRA] = 1'b1;
        default: legal = 1'b0;
      endcase
    end else begin
      dest_sel = rt;
      a_sel    = rs_val;
      case (opcode)
        6'h08: begin op_sel[OP_ADD] = 1'b1; b_sel = imm_sext; ov_sel = 1'b1; end
        6'h09: begin op_sel[OP_ADD] = 1'b1; b_sel = imm_sext; end
        6'h0A: begin op_sel[OP_SLT] = 1'b1; b_sel = imm_sext; end
        6'h0B: begin op_sel[OP_SLTU] = 1'b1; b_sel = imm_sext; end
        6'h0C: begin op_sel[OP_AND] = 1'b1; b_sel = imm_zext; end
        6'h0D: begin op_sel[OP_OR] = 1'b1; b_sel = imm_zext; end
        6'h0E: begin op_sel[OP_XOR] = 1'b1; b_sel = imm_zext; end
        6'h0F: begin op_sel[OP_LUI] = 1'b1; a_sel = '0; b_sel = imm_zext; end
        default: legal = 1'b0;
      endcase
    end
    if (legal) begin
      dec.a      = a_sel;
      dec.b      = b_sel;
      dec.op     = op_sel;
      dec.dest   = dest_sel;
      dec.wen    = (dest_sel != 5'd0);
      dec.ov_chk = ov_sel;
    end else begin
      dec.illegal = 1'b1;
    end
  end

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire;

  assign in_fire = in_valid && in_ready_q && !flush;

  // Skid buffer next state: main drains first, skid refills main, FIFO order kept.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_d = dec;
        end
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_d = dec;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_A       = main_q.a;
  assign out_B       = main_q.b;
  assign out_ALUop   = main_q.op;
  assign out_dest    = main_q.dest;
  assign out_wen     = main_q.wen;
  assign out_ov_chk  = main_q.ov_chk;
  assign out_illegal = main_q.illegal;

endmodule
